instruction_fetch: RTL
======================

# instruction_fetch

Fetch stage directly upstream of the instruction register. While the CPU state is FETCH, it reads the 32-bit word at the current PC over a simple request/acknowledge memory port. It then hands the word to the instruction register as a one-cycle `o_valid` pulse with `o_instr` on the `in`/`valid` inputs. The block also handles misaligned PCs, memory timeouts, and pipeline flushes, so the instruction register only ever sees clean, current-PC words.

## Interface
- `TIMEOUT`, default 16'd255: wait-cycle limit for a memory request. 0 disables the timeout.
- `clk`  input  1: clock; all logic on the rising edge.
- `rst`  input  1: synchronous, active-high reset.
- `state`  input  32: CPU state; FETCH is 32'h0.
- `i_pc`  input  32: address of the next instruction.
- `i_flush`  input  1: abandon the current fetch (redirect).
- `o_addr`  output  32: memory read address.
- `o_rd`  output  1: memory read request, held until acknowledged.
- `i_mem_data`  input  32: read data, valid with `i_mem_ack`.
- `i_mem_ack`  input  1: single-cycle acknowledge.
- `o_instr`  output  32: fetched word; connects to the instruction register `in`.
- `o_valid`  output  1: one-cycle delivery strobe; connects to the instruction register `valid`.
- `o_fault`  output  1: one-cycle fetch-fault strobe.
- `o_fault_cause`  output  2: 0 = misaligned PC, 1 = timeout; held until the next fault.
- `o_busy`  output  1: high in REQ and DRAIN.
- `o_fetch_count`  output  32: count of delivered instructions; wraps at 2^32.

## Operation
- **Reset:** state = IDLE. All outputs are 0: `o_addr`, `o_rd`, `o_instr`, `o_valid`, `o_fault`, `o_fault_cause`, `o_busy`, `o_fetch_count`. The timeout counter is 0.
- **States:** IDLE, REQ, DRAIN, DONE.
- **IDLE**
  - If FETCH and !`i_flush` and `i_pc[1:0]` != 0: pulse `o_fault` with cause 0, issue no bus request, go to DONE.
  - If FETCH and !`i_flush` and the PC is aligned: `o_addr` <= `i_pc`, `o_rd` <= 1, counter <= 0, go to REQ.
  - Otherwise stay in IDLE.
- **REQ:** `o_rd` = 1 and `o_addr` is stable.
  - `i_flush` has top priority.
    - With `i_mem_ack` in the same cycle: discard the data, `o_rd` <= 0, go to IDLE.
    - Without `i_mem_ack`: go to DRAIN, keeping `o_rd` = 1.
  - Else if `i_mem_ack`: `o_instr` <= `i_mem_data`, `o_valid` <= 1 for one cycle, `o_fetch_count` += 1, `o_rd` <= 0, go to DONE.
  - Else if `TIMEOUT` != 0 and counter == `TIMEOUT`-1: `o_rd` <= 0, pulse `o_fault` with cause 1, go to DONE.
  - Otherwise counter += 1 (16-bit).
- **DRAIN:** hold `o_rd` = 1 until `i_mem_ack`. Discard the data, `o_rd` <= 0, go to IDLE. No timeout applies, and `i_flush` is ignored here.
- **DONE:** remain until `state` != FETCH or `i_flush`, then go to IDLE. This guarantees exactly one delivery or fault per FETCH visit.
- `i_mem_ack` outside REQ/DRAIN is ignored: a late ack after a timeout never produces `o_valid`.
- `o_instr` holds its last delivered value between deliveries. It is never updated by discarded data.
- `o_valid` and `o_fault` are never high in the same cycle.

## Timing
- All outputs are registered.
- `o_rd` rises one cycle after IDLE samples FETCH.
- With a zero-wait memory (ack in the first `o_rd` cycle), `o_valid` is high 2 cycles after FETCH is first sampled. Each wait cycle adds 1.
- The instruction register samples `o_instr`/`o_valid` on the edge ending the `o_valid` cycle.
- A misaligned-PC fault pulse appears 1 cycle after FETCH is sampled.
- Timeout: `o_rd` stays high for exactly `TIMEOUT` cycles; `o_fault` is high in the following cycle.
- Reset asserted mid-REQ or mid-DRAIN: return to IDLE and drop `o_rd` on the next edge. A subsequent ack is ignored.

## Test plan
- **Zero-wait fetch:** `i_pc`=32'h100, state=0, memory acks in the first `o_rd` cycle with 32'h00A00093 → `o_addr`=32'h100; `o_valid` pulses once 2 cycles after FETCH with `o_instr`=32'h00A00093; `o_fetch_count`=1; no second request while state stays 0.
- **Wait states:** ack delayed 3 cycles → `o_rd` high for 4 cycles; `o_valid` 5 cycles after FETCH; `o_busy` high throughout REQ.
- **Misaligned PC:** `i_pc`=32'h102 → `o_fault`=1 with `o_fault_cause`=0 one cycle after FETCH; `o_rd` never asserted; `o_valid` never asserted.
- **Timeout:** `TIMEOUT`=4, memory never acks → `o_rd` high exactly 4 cycles, then `o_fault` with cause 1. A late ack with 32'hDEADBEEF produces no `o_valid`, and `o_instr` is unchanged.
- **Flush mid-request:** `i_flush` in the second REQ cycle, ack 2 cycles later → `o_rd` held until the ack, no `o_valid`. A new FETCH with `i_pc`=32'h200 then delivers the correct word.
- **Simultaneous flush and ack; mid-operation reset:** flush and ack in the same cycle → no `o_valid`, `o_rd` drops next cycle. `rst` during REQ → all outputs 0 next cycle, and a following ack is ignored.

Source files
------------

// File: rtl/instruction_fetch_if.sv
// Memory read port between the fetch stage and instruction memory.
//   o_addr     : read address, driven by the fetch stage
//   o_rd       : read request, held high until acknowledged
//   i_mem_data : read data, valid while i_mem_ack is high
//   i_mem_ack  : single-cycle acknowledge from memory
interface instruction_fetch_if;
    logic [31:0] o_addr;
    logic        o_rd;
    logic [31:0] i_mem_data;
    logic        i_mem_ack;

    modport master (
        output o_addr,
        output o_rd,
        input  i_mem_data,
        input  i_mem_ack
    );

    modport slave (
        input  o_addr,
        input  o_rd,
        output i_mem_data,
        output i_mem_ack
    );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage feeding the instruction register. While the CPU state is FETCH
// it reads one word at the current PC and delivers it as a one-cycle o_valid
// pulse. It also handles misaligned PCs, memory timeouts and flushes.
//
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   state          : CPU state (FETCH = 0)
//   i_pc           : address of next instruction
//   i_flush        : abandon current fetch
//   mem            : memory read port (master side)
//   o_instr        : fetched word (held between deliveries)
//   o_valid        : one-cycle delivery strobe
//   o_fault        : one-cycle fault strobe
//   o_fault_cause  : 0 = misaligned PC, 1 = timeout (held)
//   o_busy         : high while in REQ or DRAIN
//   o_fetch_count  : delivered instruction count
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for FETCH; launches request or flags misalignment
// REQ   | request outstanding; waits for ack, flush or timeout
// DRAIN | flushed request still outstanding; swallow the ack
// DONE  | one delivery/fault done; wait for FETCH to end or a flush
module instruction_fetch #(
    parameter logic [15:0] TIMEOUT = 16'd255
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [31:0]                state,
    input  logic [31:0]                i_pc,
    input  logic                       i_flush,
    instruction_fetch_if.master        mem,
    output logic [31:0]                o_instr,
    output logic                       o_valid,
    output logic                       o_fault,
    output logic [1:0]                 o_fault_cause,
    output logic                       o_busy,
    output logic [31:0]                o_fetch_count
);

    typedef enum logic [1:0] {IDLE, REQ, DRAIN, DONE} fsm_t;

    localparam logic [31:0] FETCH   = 32'h0;
    localparam logic [15:0] TO_LAST = TIMEOUT - 16'd1;

    fsm_t        fsm_q, fsm_n;
    logic [31:0] addr_q, addr_n;
    logic        rd_q, rd_n;
    logic [31:0] instr_q, instr_n;
    logic        valid_q, valid_n;
    logic        fault_q, fault_n;
    logic [1:0]  cause_q, cause_n;
    logic        busy_q, busy_n;
    logic [31:0] count_q, count_n;
    logic [15:0] timer_q, timer_n;

    logic fetch;
    assign fetch = (state == FETCH);

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= IDLE;
            addr_q  <= '0;
            rd_q    <= 1'b0;
            instr_q <= '0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            cause_q <= '0;
            busy_q  <= 1'b0;
            count_q <= '0;
            timer_q <= '0;
        end else begin
            fsm_q   <= fsm_n;
            addr_q  <= addr_n;
            rd_q    <= rd_n;
            instr_q <= instr_n;
            valid_q <= valid_n;
            fault_q <= fault_n;
            cause_q <= cause_n;
            busy_q  <= busy_n;
            count_q <= count_n;
            timer_q <= timer_n;
        end
    end

    always_comb begin
        fsm_n   = fsm_q;
        addr_n  = addr_q;
        rd_n    = rd_q;
        instr_n = instr_q;
        valid_n = 1'b0;
        fault_n = 1'b0;
        cause_n = cause_q;
        busy_n  = busy_q;
        count_n = count_q;
        timer_n = timer_q;

        case (fsm_q)
            IDLE: begin
                if (fetch && !i_flush) begin
                    if (i_pc[1:0] != 2'b00) begin
                        fault_n = 1'b1;
                        cause_n = 2'd0;
                        fsm_n   = DONE;
                    end else begin
                        addr_n  = i_pc;
                        rd_n    = 1'b1;
                        timer_n = '0;
                        busy_n  = 1'b1;
                        fsm_n   = REQ;
                    end
                end
            end
            REQ: begin
                if (i_flush) begin
                    if (mem.i_mem_ack) begin
                        rd_n   = 1'b0;
                        busy_n = 1'b0;
                        fsm_n  = IDLE;
                    end else begin
                        fsm_n  = DRAIN;
                    end
                end else if (mem.i_mem_ack) begin
                    instr_n = mem.i_mem_data;
                    valid_n = 1'b1;
                    count_n = count_q + 32'd1;
                    rd_n    = 1'b0;
                    busy_n  = 1'b0;
                    fsm_n   = DONE;
                end else if ((TIMEOUT != 16'd0) && (timer_q == TO_LAST)) begin
                    rd_n    = 1'b0;
                    busy_n  = 1'b0;
                    fault_n = 1'b1;
                    cause_n = 2'd1;
                    fsm_n   = DONE;
                end else begin
                    timer_n = timer_q + 16'd1;
                end
            end
            DRAIN: begin
                // flush already taken; only the outstanding ack matters
                if (mem.i_mem_ack) begin
                    rd_n   = 1'b0;
                    busy_n = 1'b0;
                    fsm_n  = IDLE;
                end
            end
            DONE: begin
                if (!fetch || i_flush) begin
                    fsm_n = IDLE;
                end
            end
            default: fsm_n = IDLE;
        endcase
    end

    assign mem.o_addr    = addr_q;
    assign mem.o_rd      = rd_q;
    assign o_instr       = instr_q;
    assign o_valid       = valid_q;
    assign o_fault       = fault_q;
    assign o_fault_cause = cause_q;
    assign o_busy        = busy_q;
    assign o_fetch_count = count_q;

endmodule
